// File: rtl/rx_word_fifo.sv
// rx_word_fifo
//   Packs bytes from the UART receiver into 32-bit little-endian words and
//   buffers them in a first-word-fall-through FIFO. The consumer reads the
//   words over a valid/ready handshake.
//
//   The receiver cannot be stalled. A completed word that arrives while the
//   FIFO is full, with no pop in the same cycle, is dropped. The sticky
//   overflow flag then records the loss.
//
// Parameters
//   DEPTH_LOG2  FIFO depth = 2**DEPTH_LOG2 words (legal range 1..10)
//
// Ports
//   CLK        system clock, rising edge
//   RST        asynchronous reset, active-high
//   in_data    received byte
//   in_valid   1-cycle strobe qualifying in_data
//   out_data   word at the FIFO head (meaningful while out_valid=1)
//   out_valid  FIFO non-empty
//   out_ready  consumer takes the head word this cycle
//   count      number of stored words (registered)
//   overflow   sticky: a completed word was dropped because the FIFO was full
//   flush      (RX_WORD_FLUSH_EN only) push the partial word, zero-padded
//
// Configuration
//   Define RX_WORD_FLUSH_EN to add the flush port. Without it, partial bytes
//   are held until the word completes or RST is asserted.

module rx_word_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
`ifdef RX_WORD_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned PtrW  = DEPTH_LOG2 + 1;

  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [23:0]     partial_q, partial_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;

  logic [31:0]     mem [Depth];

  logic [31:0]     asm_word;
  logic            flush_req;
  logic            word_done;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            wr_en;

`ifdef RX_WORD_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Byte slots at and above byte_idx are always zero in partial_q. That lets
  // a flushed word come out zero-padded with no extra masking.
  always_comb begin
    asm_word = {8'h00, partial_q};
    if (in_valid) begin
      asm_word[{byte_idx_q, 3'b000} +: 8] = in_data;
    end
  end

  assign word_done = in_valid && (byte_idx_q == 2'd3);
  // A flush that coincides with a word-completing byte adds nothing: the
  // push from word_done already covers it.
  assign push      = word_done || (flush_req && (in_valid || (byte_idx_q != 2'd0)));

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);
  assign pop   = !empty && out_ready;
  // When the FIFO is full, a pop in the same cycle frees the slot the push needs.
  assign wr_en = push && (!full || pop);

  always_comb begin
    byte_idx_d = byte_idx_q;
    partial_d  = partial_q;
    if (push) begin
      byte_idx_d = 2'd0;
      partial_d  = 24'h000000;
    end else if (in_valid) begin
      byte_idx_d = byte_idx_q + 2'd1;
      partial_d  = asm_word[23:0];
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !wr_en) begin
      overflow_d = 1'b1;
    end
    count_d = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      byte_idx_q <= 2'd0;
      partial_q  <= 24'h000000;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      byte_idx_q <= byte_idx_d;
      partial_q  <= partial_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr_q[PtrW-2:0]] <= asm_word;
    end
  end

  assign out_data  = mem[rd_ptr_q[PtrW-2:0]];
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_rx_word_fifo.sv
module tb_rx_word_fifo;

  localparam int unsigned DL2 = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic [7:0]   in_data;
  logic         in_valid;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [DL2:0] count;
  logic         overflow;
  logic         flush;

  int n_cmp = 0;
  int n_bad = 0;

  rx_word_fifo #(
    .DEPTH_LOG2(DL2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count),
    .overflow (overflow)
`ifdef RX_WORD_FLUSH_EN
    ,
    .flush    (flush)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Every step leaves the time 1 ns after a rising edge. Inputs are driven there
  // and outputs are sampled there.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    step();
    RST = 1'b0;
  endtask

  initial begin
    RST       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2;
    check_eq("init_count", 32'(count), 32'd0);
    check_eq("init_valid", 32'(out_valid), 32'd0);
    check_eq("init_overflow", 32'(overflow), 32'd0);
    step();
    step();
    RST = 1'b0;

    // 1: single word, LSB first, visible one cycle after the 4th strobe.
    out_ready = 1'b1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check_eq("t1_partial_valid", 32'(out_valid), 32'd0);
    send_byte(8'h44);
    check_eq("t1_valid", 32'(out_valid), 32'd1);
    check_eq("t1_data", out_data, 32'h44332211);
    check_eq("t1_count", 32'(count), 32'd1);
    step();
    check_eq("t1_valid_after_pop", 32'(out_valid), 32'd0);
    check_eq("t1_count_after_pop", 32'(count), 32'd0);
    out_ready = 1'b0;

    // 2: fill, overflow, then drain in order.
    for (int i = 0; i < 16; i++) begin
      send_word(32'(i));
    end
    check_eq("t2_full_count", 32'(count), 32'd16);
    check_eq("t2_full_overflow", 32'(overflow), 32'd0);
    send_word(32'h0000_0010);
    check_eq("t2_ovf_flag", 32'(overflow), 32'd1);
    check_eq("t2_ovf_count", 32'(count), 32'd16);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("t2_drain_valid%0d", i), 32'(out_valid), 32'd1);
      check_eq($sformatf("t2_drain_data%0d", i), out_data, 32'(i));
      step();
    end
    check_eq("t2_empty", 32'(out_valid), 32'd0);
    check_eq("t2_sticky", 32'(overflow), 32'd1);
    out_ready = 1'b0;

    // 3: push and pop in the same cycle while full.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send_word(32'h100 + 32'(i));
    end
    send_byte(8'h0D);
    send_byte(8'hF0);
    send_byte(8'hFE);
    in_data   = 8'hCA;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("t3_count", 32'(count), 32'd16);
    check_eq("t3_overflow", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check_eq($sformatf("t3_drain%0d", i), out_data, 32'h100 + 32'(i));
      step();
    end
    check_eq("t3_last_valid", 32'(out_valid), 32'd1);
    check_eq("t3_last_data", out_data, 32'hCAFEF00D);
    step();
    check_eq("t3_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // 4: reset discards a partial word.
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset();
    check_eq("t4_count_after_rst", 32'(count), 32'd0);
    send_word(32'h0403_0201);
    check_eq("t4_data", out_data, 32'h04030201);
    check_eq("t4_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    check_eq("t4_single", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // 5: back-to-back strobes.
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i));
    end
    check_eq("t5_count", 32'(count), 32'd2);
    check_eq("t5_word0", out_data, 32'h03020100);
    out_ready = 1'b1;
    step();
    check_eq("t5_word1", out_data, 32'h07060504);
    step();
    check_eq("t5_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

`ifdef RX_WORD_FLUSH_EN
    // 6: flush behaviour.
    send_byte(8'hDE);
    send_byte(8'hAD);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("t6_flush_count", 32'(count), 32'd1);
    check_eq("t6_flush_data", out_data, 32'h0000ADDE);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("t6_noop_count", 32'(count), 32'd0);
    send_byte(8'h01);
    in_data  = 8'h02;
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    check_eq("t6_coinc_data", out_data, 32'h00000201);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    send_byte(8'h05);
    send_byte(8'h06);
    send_byte(8'h07);
    in_data  = 8'h08;
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    step();
    check_eq("t6_full_coinc_count", 32'(count), 32'd1);
    check_eq("t6_full_coinc_data", out_data, 32'h08070605);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
